// File: rtl/seq_alu.sv
// seq_alu: registered ALU with a start/busy/done handshake.
// Single-cycle operations finish on the edge that accepts start. MULTU
// (shift-add) and DIVU with a non-zero divisor (restoring division) produce
// one bit per cycle and finish WIDTH edges after start is accepted.
// Results stay in the output registers until the next operation completes.
module seq_alu #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [3:0]         alu_op,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic [SHAMT_W-1:0] shamt,
   output logic               busy,
   output logic               done,
   output logic               zero,
   output logic               overflow,
   output logic [WIDTH-1:0]   result_lo,
   output logic [WIDTH-1:0]   result_hi
);

   localparam int HALF  = WIDTH / 2;
   localparam int CNT_W = $clog2(WIDTH) + 1;

   localparam logic [3:0] OP_AND   = 4'b0000;
   localparam logic [3:0] OP_OR    = 4'b0001;
   localparam logic [3:0] OP_NOR   = 4'b0010;
   localparam logic [3:0] OP_ADD   = 4'b0011;
   localparam logic [3:0] OP_SUB   = 4'b0100;
   localparam logic [3:0] OP_SLL   = 4'b0101;
   localparam logic [3:0] OP_SRL   = 4'b0110;
   localparam logic [3:0] OP_MULTU = 4'b0111;
   localparam logic [3:0] OP_DIVU  = 4'b1000;
   localparam logic [3:0] OP_SRA   = 4'b1001;
   localparam logic [3:0] OP_SLT   = 4'b1010;
   localparam logic [3:0] OP_ORI   = 4'b1100;
   localparam logic [3:0] OP_LUI   = 4'b1101;
   localparam logic [3:0] OP_ADDI  = 4'b1110;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2
   } state_e;

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     count_q, count_d;
   logic [WIDTH-1:0]     opnd_q, opnd_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]     resLo_q, resLo_d;
   logic [WIDTH-1:0]     resHi_q, resHi_d;
   logic                 zero_q, zero_d;
   logic                 ovf_q, ovf_d;
   logic                 done_q, done_d;

   logic [WIDTH-1:0]     sumAB, diffAB;
   logic                 sltBit;
   logic [WIDTH-1:0]     scLo, scHi;
   logic                 scOvf;
   logic                 lastIter;

   logic [WIDTH-1:0]     mulAddend;
   logic [WIDTH:0]       mulSum;
   logic [2*WIDTH-1:0]   mulNext;
   logic [WIDTH:0]       divShift, divDiff;
   logic                 divFits;
   logic [WIDTH-1:0]     divRemNext;
   logic [2*WIDTH-1:0]   divNext;

   // Result of every operation that completes in the same cycle it is accepted
   always_comb begin
      sumAB  = a + b;
      diffAB = a - b;
      sltBit = $signed(a) < $signed(b);
      scLo   = '0;
      scHi   = '0;
      scOvf  = 1'b0;
      case (alu_op)
         OP_AND:  scLo = a & b;
         OP_OR:   scLo = a | b;
         OP_NOR:  scLo = ~(a | b);
         OP_ADD, OP_ADDI: begin
            scLo  = sumAB;
            scOvf = (a[WIDTH-1] == b[WIDTH-1]) && (sumAB[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            scLo  = diffAB;
            scOvf = (a[WIDTH-1] != b[WIDTH-1]) && (diffAB[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SLL:  scLo = a << shamt;
         OP_SRL:  scLo = a >> shamt;
         OP_SRA:  scLo = $signed(a) >>> shamt;
         OP_SLT:  scLo = {{(WIDTH-1){1'b0}}, sltBit};
         OP_ORI:  scLo = a | b;
         OP_LUI:  scLo = {b[HALF-1:0], {HALF{1'b0}}};
         OP_DIVU: begin
            scLo  = '1;
            scHi  = a;
            scOvf = 1'b1;
         end
         default: begin
            scLo  = '0;
            scHi  = '0;
            scOvf = 1'b0;
         end
      endcase
   end

   // One shift-add multiply step and one restoring divide step on the accumulator
   always_comb begin
      mulAddend  = acc_q[0] ? opnd_q : '0;
      mulSum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mulAddend};
      mulNext    = {mulSum, acc_q[WIDTH-1:1]};
      divShift   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      divDiff    = divShift - {1'b0, opnd_q};
      divFits    = ~divDiff[WIDTH];
      divRemNext = divFits ? divDiff[WIDTH-1:0] : divShift[WIDTH-1:0];
      divNext    = {divRemNext, acc_q[WIDTH-2:0], divFits};
   end

   assign lastIter = (count_q == CNT_W'(WIDTH - 1));

   // Next-state logic: accept work in IDLE, iterate in MUL/DIV, write results on completion
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      opnd_d  = opnd_q;
      acc_d   = acc_q;
      resLo_d = resLo_q;
      resHi_d = resHi_q;
      zero_d  = zero_q;
      ovf_d   = ovf_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (alu_op == OP_MULTU) begin
                  opnd_d  = a;
                  acc_d   = {{WIDTH{1'b0}}, b};
                  count_d = '0;
                  state_d = MUL;
               end else if ((alu_op == OP_DIVU) && (b != '0)) begin
                  opnd_d  = b;
                  acc_d   = {{WIDTH{1'b0}}, a};
                  count_d = '0;
                  state_d = DIV;
               end else begin
                  resLo_d = scLo;
                  resHi_d = scHi;
                  zero_d  = (scLo == '0);
                  ovf_d   = scOvf;
                  done_d  = 1'b1;
               end
            end
         end
         MUL: begin
            acc_d   = mulNext;
            count_d = count_q + CNT_W'(1);
            if (lastIter) begin
               state_d = IDLE;
               resLo_d = mulNext[WIDTH-1:0];
               resHi_d = mulNext[2*WIDTH-1:WIDTH];
               zero_d  = (mulNext == '0);
               ovf_d   = 1'b0;
               done_d  = 1'b1;
            end
         end
         DIV: begin
            acc_d   = divNext;
            count_d = count_q + CNT_W'(1);
            if (lastIter) begin
               state_d = IDLE;
               resLo_d = divNext[WIDTH-1:0];
               resHi_d = divNext[2*WIDTH-1:WIDTH];
               zero_d  = (divNext[WIDTH-1:0] == '0);
               ovf_d   = 1'b0;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and result registers; reset aborts any iteration without a done pulse
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         count_q <= '0;
         opnd_q  <= '0;
         acc_q   <= '0;
         resLo_q <= '0;
         resHi_q <= '0;
         zero_q  <= 1'b0;
         ovf_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         opnd_q  <= opnd_d;
         acc_q   <= acc_d;
         resLo_q <= resLo_d;
         resHi_q <= resHi_d;
         zero_q  <= zero_d;
         ovf_q   <= ovf_d;
         done_q  <= done_d;
      end
   end

   assign busy      = (state_q != IDLE);
   assign done      = done_q;
   assign zero      = zero_q;
   assign overflow  = ovf_q;
   assign result_lo = resLo_q;
   assign result_hi = resHi_q;

endmodule

// File: tb/tb_seq_alu.sv
// Testbench for seq_alu: a 32-bit and an 8-bit instance share clock and reset.
// The driver pushes reference-model results into per-instance queues; the
// monitor pops them whenever done is seen and compares value and timing.
module tb_seq_alu;

   typedef struct packed {
      logic [31:0] lo;
      logic [31:0] hi;
      logic        zero;
      logic        ovf;
      logic        multi;
      int unsigned startCyc;
      int unsigned doneCyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;

   logic        start32, busy32, done32, zero32, ovf32;
   logic [3:0]  op32;
   logic [31:0] a32, b32, lo32, hi32;
   logic [4:0]  shamt32;

   logic        start8, busy8, done8, zero8, ovf8;
   logic [3:0]  op8;
   logic [7:0]  a8, b8, lo8, hi8;
   logic [2:0]  shamt8;

   int unsigned cyc = 0;
   int unsigned abortStart = 0;
   int unsigned abortEnd = 0;
   int          checks = 0;
   int          errors = 0;
   exp_t        q32[$];
   exp_t        q8[$];

   seq_alu #(.WIDTH(32)) dut32 (
      .clk(clk), .reset(reset), .start(start32), .alu_op(op32), .a(a32), .b(b32),
      .shamt(shamt32), .busy(busy32), .done(done32), .zero(zero32),
      .overflow(ovf32), .result_lo(lo32), .result_hi(hi32)
   );

   seq_alu #(.WIDTH(8)) dut8 (
      .clk(clk), .reset(reset), .start(start8), .alu_op(op8), .a(a8), .b(b8),
      .shamt(shamt8), .busy(busy8), .done(done8), .zero(zero8),
      .overflow(ovf8), .result_lo(lo8), .result_hi(hi8)
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Cycle counter: equals the number of rising edges seen so far
   always @(posedge clk) cyc <= cyc + 1;

   // Reference model: plain integer arithmetic on w-bit values
   function automatic exp_t model(input int w, input logic [3:0] op, input logic [31:0] av,
                                  input logic [31:0] bv, input int sh);
      exp_t e;
      longint unsigned mask, ua, ub, res, prod;
      longint sa, sb, sres, lim;
      e    = '0;
      res  = 64'd0;
      prod = 64'd0;
      mask = (64'd1 << w) - 64'd1;
      ua   = {32'd0, av} & mask;
      ub   = {32'd0, bv} & mask;
      lim  = 64'sd1 << (w - 1);
      sa   = $signed(ua);
      if (sa >= lim) sa = sa - (lim * 2);
      sb   = $signed(ub);
      if (sb >= lim) sb = sb - (lim * 2);
      case (op)
         4'b0000: res = ua & ub;
         4'b0001, 4'b1100: res = ua | ub;
         4'b0010: res = ~(ua | ub) & mask;
         4'b0011, 4'b1110: begin
            sres  = sa + sb;
            res   = $unsigned(sres) & mask;
            e.ovf = (sres >= lim) || (sres < -lim);
         end
         4'b0100: begin
            sres  = sa - sb;
            res   = $unsigned(sres) & mask;
            e.ovf = (sres >= lim) || (sres < -lim);
         end
         4'b0101: res = (ua << sh) & mask;
         4'b0110: res = ua >> sh;
         4'b1001: res = $unsigned(sa >>> sh) & mask;
         4'b1010: res = (sa < sb) ? 64'd1 : 64'd0;
         4'b1101: res = ((ub & ((64'd1 << (w / 2)) - 64'd1)) << (w / 2)) & mask;
         4'b0111: begin
            prod    = ua * ub;
            res     = prod & mask;
            e.hi    = 32'((prod >> w) & mask);
            e.multi = 1'b1;
         end
         4'b1000: begin
            if (ub == 64'd0) begin
               res   = mask;
               e.hi  = 32'(ua);
               e.ovf = 1'b1;
            end else begin
               res     = ua / ub;
               e.hi    = 32'(ua % ub);
               e.multi = 1'b1;
            end
         end
         default: res = 64'd0;
      endcase
      e.lo   = 32'(res);
      e.zero = (op == 4'b0111) ? (prod == 64'd0) : (res == 64'd0);
      return e;
   endfunction

   // Operand generator biased toward corner values of a w-bit word
   function automatic logic [31:0] randOperand(input int w);
      logic [31:0] msb;
      msb = 32'h8000_0000 >> (32 - w);
      case ($urandom_range(5, 0))
         0: return 32'd0;
         1: return 32'hFFFF_FFFF;
         2: return msb;
         3: return msb - 32'd1;
         4: return $urandom_range(15, 0);
         default: return $urandom;
      endcase
   endfunction

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   task automatic setInputs(input int w, input logic s, input logic [3:0] op,
                            input logic [31:0] av, input logic [31:0] bv, input int sh);
      if (w == 32) begin
         start32 = s; op32 = op; a32 = av; b32 = bv; shamt32 = 5'(sh);
      end else begin
         start8 = s; op8 = op; a8 = av[7:0]; b8 = bv[7:0]; shamt8 = 3'(sh);
      end
   endtask

   // Issue one operation (called at a falling edge) and scramble inputs while it is busy
   task automatic applyStimulus(input int w, input logic [3:0] op, input logic [31:0] av,
                                input logic [31:0] bv, input int sh);
      exp_t e;
      e          = model(w, op, av, bv, sh);
      e.startCyc = cyc + 32'd1;
      e.doneCyc  = cyc + 32'd1 + (e.multi ? 32'(w) : 32'd0);
      if (w == 32) q32.push_back(e);
      else         q8.push_back(e);
      setInputs(w, 1'b1, op, av, bv, sh);
      @(negedge clk);
      if (e.multi) begin
         for (int i = 0; i < w; i++) begin
            setInputs(w, 1'($urandom_range(1, 0)), 4'($urandom_range(15, 0)),
                      $urandom, $urandom, int'($urandom_range(w - 1, 0)));
            @(negedge clk);
         end
      end
      setInputs(w, 1'b0, op, av, bv, sh);
   endtask

   // Monitor step for one instance: busy every cycle, results and timing on done
   task automatic checkOutput(input int w);
      exp_t        e;
      logic        have, dn, bs, zr, ov, expBusy;
      logic [31:0] lo, hi;
      string       tag;
      e = '0;
      if (w == 32) begin
         dn = done32; bs = busy32; zr = zero32; ov = ovf32; lo = lo32; hi = hi32;
         have = (q32.size() != 0);
         if (have) e = q32[0];
         tag = "w32";
      end else begin
         dn = done8; bs = busy8; zr = zero8; ov = ovf8; lo = 32'(lo8); hi = 32'(hi8);
         have = (q8.size() != 0);
         if (have) e = q8[0];
         tag = "w8";
      end
      expBusy = have && e.multi && (cyc >= e.startCyc) && (cyc < e.doneCyc);
      if ((w == 32) && (cyc >= abortStart) && (cyc < abortEnd)) expBusy = 1'b1;
      cmp({tag, " busy"}, 32'(bs), 32'(expBusy));
      if (dn) begin
         if (!have) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s done: got unexpected done, expected none (cycle %0d)", tag, cyc);
         end else begin
            if (w == 32) void'(q32.pop_front());
            else         void'(q8.pop_front());
            cmp({tag, " doneCycle"}, cyc, e.doneCyc);
            cmp({tag, " result_lo"}, lo, e.lo);
            cmp({tag, " result_hi"}, hi, e.hi);
            cmp({tag, " zero"}, 32'(zr), 32'(e.zero));
            cmp({tag, " overflow"}, 32'(ov), 32'(e.ovf));
         end
      end else if (have && (cyc >= e.doneCyc)) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s done timeout: got no done, expected done at cycle %0d", tag, e.doneCyc);
         if (w == 32) void'(q32.pop_front());
         else         void'(q8.pop_front());
      end
   endtask

   // Monitor process, sampling away from the rising edge
   always @(negedge clk) begin
      checkOutput(32);
      checkOutput(8);
   end

   // Hard stop in case the stimulus itself stalls
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got no end of test, expected finish before time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   logic [3:0]  dOp[16] = '{4'b0011, 4'b0100, 4'b1010, 4'b1001, 4'b0010, 4'b1101,
                            4'b1100, 4'b0000, 4'b0101, 4'b0110, 4'b1011, 4'b0111,
                            4'b1000, 4'b1000, 4'b1110, 4'b0100};
   logic [31:0] dA[16]  = '{32'h7FFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,
                            32'd0, 32'h00F0_0000, 32'hF0F0_F0F0, 32'd1, 32'h8000_0000,
                            32'h1234_5678, 32'hFFFF_FFFF, 32'd100, 32'd9,
                            32'h8000_0000, 32'h8000_0000};
   logic [31:0] dB[16]  = '{32'd1, 32'd5, 32'd1, 32'd0, 32'd0, 32'h1234_ABCD,
                            32'h0000_0F0F, 32'hFF00_FF00, 32'd0, 32'd0, 32'd7,
                            32'hFFFF_FFFF, 32'd7, 32'd0, 32'hFFFF_FFFF, 32'd1};
   int          dSh[16] = '{0, 0, 0, 4, 0, 0, 0, 0, 31, 31, 0, 0, 0, 0, 0, 0};

   // Test sequence
   initial begin
      reset = 1'b1;
      setInputs(32, 1'b1, 4'b0011, 32'h7FFF_FFFF, 32'd1, 0);
      setInputs(8, 1'b1, 4'b0011, 32'h7F, 32'd1, 0);
      repeat (3) @(negedge clk);
      cmp("reset busy", 32'(busy32), 32'd0);
      cmp("reset done", 32'(done32), 32'd0);
      cmp("reset zero", 32'(zero32), 32'd0);
      cmp("reset overflow", 32'(ovf32), 32'd0);
      cmp("reset result_lo", lo32, 32'd0);
      cmp("reset result_hi", hi32, 32'd0);
      cmp("reset w8 result_lo", 32'(lo8), 32'd0);
      reset = 1'b0;
      setInputs(32, 1'b0, 4'b0011, 32'd0, 32'd0, 0);
      setInputs(8, 1'b0, 4'b0011, 32'd0, 32'd0, 0);
      @(negedge clk);
      cmp("after reset done", 32'(done32), 32'd0);

      for (int i = 0; i < 16; i++) applyStimulus(32, dOp[i], dA[i], dB[i], dSh[i]);

      // Reset on the tenth cycle of a multiply: no done, outputs cleared
      setInputs(32, 1'b1, 4'b0111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      abortStart = cyc + 32'd1;
      abortEnd   = cyc + 32'd11;
      @(negedge clk);
      setInputs(32, 1'b0, 4'b0011, 32'd0, 32'd0, 0);
      repeat (9) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      cmp("abort busy", 32'(busy32), 32'd0);
      cmp("abort done", 32'(done32), 32'd0);
      cmp("abort result_lo", lo32, 32'd0);
      cmp("abort result_hi", hi32, 32'd0);
      cmp("abort zero", 32'(zero32), 32'd0);
      reset = 1'b0;
      applyStimulus(32, 4'b0011, 32'd3, 32'd4, 0);

      for (int i = 0; i < 150; i++)
         applyStimulus(32, 4'($urandom_range(15, 0)), randOperand(32), randOperand(32),
                       int'($urandom_range(31, 0)));

      applyStimulus(8, 4'b0111, 32'hFF, 32'hFF, 0);
      applyStimulus(8, 4'b1000, 32'd100, 32'd7, 0);
      applyStimulus(8, 4'b0111, 32'd16, 32'd16, 0);
      applyStimulus(8, 4'b1000, 32'd9, 32'd0, 0);
      applyStimulus(8, 4'b0011, 32'h7F, 32'd1, 0);
      applyStimulus(8, 4'b1101, 32'd0, 32'hAB, 0);
      for (int i = 0; i < 150; i++)
         applyStimulus(8, 4'($urandom_range(15, 0)), randOperand(8), randOperand(8),
                       int'($urandom_range(7, 0)));

      for (int i = 0; (i < 100) && ((q32.size() != 0) || (q8.size() != 0)); i++)
         @(negedge clk);
      if ((q32.size() != 0) || (q8.size() != 0)) begin
         checks++;
         errors++;
         $display("[TB] FAIL drain: got %0d/%0d pending results, expected 0/0", q32.size(), q8.size());
      end
      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, registered successor to the datapath's single-cycle ALU. It keeps the existing 4-bit operation encoding and adds signed set-less-than, arithmetic shift right, iterative unsigned multiply and iterative unsigned divide. It uses a start/busy/done handshake so the multi-cycle processor control can stall on long operations. All results are registered into LO/HI-style outputs that hold until the next operation completes.

## Interface
Parameters:
- WIDTH, 32, operand/result width; even, ≥ 8
- SHAMT_W, $clog2(WIDTH), shift-amount width

Ports:
- clk  in  1  rising-edge clock; one clock domain
- reset  in  1  synchronous, active-high; one clock, sampled on the rising edge of clk
- start  in  1  request; sampled only when idle (busy=0)
- alu_op  in  4  operation code
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- shamt  in  SHAMT_W  shift amount
- busy  out  1  iterative operation in progress
- done  out  1  one-cycle pulse; results valid from this cycle
- zero  out  1  completed result equals 0
- overflow  out  1  signed overflow (ADD/SUB/ADDI) or divide-by-zero (DIVU)
- result_lo  out  WIDTH  primary result; quotient for DIVU, low product for MULTU
- result_hi  out  WIDTH  remainder for DIVU, high product for MULTU, 0 otherwise

## Operation
- Opcodes: AND 0000, OR 0001, NOR 0010, ADD 0011, SUB 0100, SLL 0101 (a<<shamt), SRL 0110 (a>>shamt), MULTU 0111, DIVU 1000, SRA 1001 (signed a>>>shamt), SLT 1010 (signed a<b → 1, else 0), ORI 1100 (a|b), LUI 1101 ({b[WIDTH/2-1:0], WIDTH/2 zeros}), ADDI 1110 (a+b). All other codes are undefined: result 0, zero=1, overflow=0.
- Arithmetic wraps modulo 2^WIDTH.
- overflow for ADD/ADDI/SUB uses the signed rule: operand signs agree (ADD) or differ (SUB), and the result sign differs from a. overflow=0 for all other ops except DIVU by zero.
- States: IDLE, MUL, DIV.
  - IDLE + start + single-cycle op (everything except MULTU and non-zero DIVU): register result, pulse done, stay IDLE.
  - IDLE + start + MULTU: latch a and b, count=0, go to MUL.
  - IDLE + start + DIVU with b≠0: latch a and b, count=0, go to DIV.
  - IDLE + start + DIVU with b=0: single-cycle. result_lo = all ones, result_hi = a, overflow=1.
  - MUL uses shift-add, one multiplier bit per cycle. DIV uses restoring division, one quotient bit per cycle.
  - After WIDTH iterations: write the results, pulse done, return to IDLE.
- zero: for MULTU, set when {result_hi,result_lo}==0; for all other ops, set when result_lo==0.
- start and operand changes while busy are ignored. Operands are captured when start is accepted.
- Outputs hold their last completed values between operations.
- reset: state IDLE; busy, done, zero, overflow, result_lo, result_hi all 0. Reset during MUL/DIV aborts the operation with no done pulse.

## Timing
- Single-cycle op: start is accepted at edge k. At edge k, result/zero/overflow are registered and done=1 for the cycle after edge k. Latency 1.
- MULTU / DIVU (b≠0): start is accepted at edge k, and busy=1 from edge k. Iterations run on edges k+1 … k+WIDTH. At edge k+WIDTH the results are registered, busy falls and done=1 for one cycle. Latency WIDTH.
- done is never asserted for two consecutive operations without an edge between them. A new start may be accepted in the same cycle done is high, because state is already IDLE. Back-to-back single-cycle ops give done every cycle.
- reset takes priority over start on the same edge.

## Test plan
- Reset with start=1, op=ADD → all outputs 0, busy=0, no done on the following edge.
- WIDTH=32: ADD a=0x7FFFFFFF, b=1 → result_lo=0x80000000, overflow=1, zero=0, done 1 cycle after start. SUB a=5, b=5 → zero=1. SLT a=0xFFFFFFFF, b=1 → result_lo=1. SRA a=0x80000000, shamt=4 → 0xF8000000.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → busy for 32 cycles; result_hi=0xFFFFFFFE, result_lo=0x00000001, done exactly 32 edges after start. Changing a and b while busy leaves the result unaffected.
- DIVU a=100, b=7 → result_lo=14, result_hi=2 after 32 cycles. DIVU a=9, b=0 → result_lo=0xFFFFFFFF, result_hi=9, overflow=1, done after 1 cycle.
- Assert reset at cycle 10 of a MULTU → no done, busy=0 next cycle, outputs 0. Start a new ADD immediately after: it completes normally.
- Re-run the MULTU and DIVU checks at WIDTH=8 (MULTU 255×255 → hi=0xFE, lo=0x01, 8-cycle latency), and issue back-to-back start on the done cycle → second operation is accepted with no lost request.
